mips_regfile_sb: RTL
====================

Name: mips_regfile_sb

Overview:
- Parametrised MIPS general-purpose register file; next generation of the 2R1W core register file.
- Adds configurable width, depth and read-port count, a hardwired zero register, and write-to-read bypass.
- Adds an integrated scoreboard: per-register busy bits that the decode stage uses to detect RAW hazards.
- Sits between decode (read and reserve) and writeback (write and release).

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- we  in  1  writeback write enable.
- wa  in  ADDR_W  writeback address.
- wd  in  DATA_W  writeback data.
- wclr  in  1  writeback releases the busy bit of wa (normally = we).
- ra  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd  out  NUM_RD*DATA_W  read data, same packing as ra.
- rbusy  out  NUM_RD  port k reads a register with a pending producer.
- rsv  in  1  decode reserves destination rsv_a (instruction issued).
- rsv_a  in  ADDR_W  destination register to mark busy.
- any_busy  out  1  OR of all busy bits (drain/flush indicator).

Behaviour:
- Reset is asynchronous on rst low, with no clock required:
  - all registers clear to 0 and all busy bits clear to 0;
  - outputs settle to rd = 0, rbusy = 0, any_busy = 0.
- Register 0:
  - always reads 0; writes to it are dropped;
  - its busy bit is never set (rsv to 0 is ignored) and rbusy for address 0 is always 0.
- Writes:
  - on a rising clk with we = 1 and wa != 0, regs[wa] <= wd (nonblocking);
  - the value is visible in storage from the next cycle.
- Reads are combinational, zero latency.
  - BYPASS = 1: if we = 1, wa != 0 and ra_k == wa, then rd_k = wd in the same cycle.
  - Otherwise rd_k = regs[ra_k].
- Busy vector (sequential, NUM_REGS bits):
  - rsv = 1 and rsv_a != 0 → busy[rsv_a] <= 1.
  - wclr = 1 and wa != 0 → busy[wa] <= 0.
  - Same address on both in the same cycle: set wins, because the new producer supersedes the retiring one; busy stays 1.
  - Different addresses: both take effect.
- rbusy_k:
  - rbusy_k = busy[ra_k], masked to 0 when BYPASS = 1 and the write bypass hits that port this cycle (the data is already valid).
  - A reserve in the current cycle does not affect rbusy until the next cycle.
- any_busy = |busy, registered state only.
- Only one outstanding producer per register is tracked. Decode must stall on rbusy before reissuing to a busy destination; that behaviour is not checked here.
- Out-of-range parameter NUM_RD outside 1..4: elaboration error via generate-time check.
- Reset asserted mid-operation clears storage and the scoreboard immediately; in-flight writes in that cycle are lost.

Decomposition:
- Package mips_rf_pkg:
  - DATA_W_DEF, ADDR_W_DEF, ZERO_REG = 0;
  - typedefs reg_addr_t and reg_data_t.
- Sub-module rf_read_port, instantiated NUM_RD times with generate. It contains:
  - the address mux;
  - the zero-register mask;
  - the bypass compare;
  - the rbusy lookup.
- Storage and the busy vector remain in the top.

Test Plan:
- Reset: hold rst = 0 with registers preloaded by writes → all rd = 0, rbusy = 0, any_busy = 0 asynchronously, before any clk edge.
- Write/read: we = 1, wa = 5, wd = 0xDEADBEEF, ra0 = 5 → same-cycle rd0 = 0xDEADBEEF with BYPASS = 1 (stale 0 with BYPASS = 0); next cycle rd0 = 0xDEADBEEF in both builds.
- Zero register: we = 1, wa = 0, wd = 0x12345678, then ra1 = 0 → rd1 = 0. Also rsv = 1, rsv_a = 0 → rbusy = 0 and any_busy stays 0.
- Scoreboard:
  - rsv = 1, rsv_a = 7 → next cycle rbusy = 1 on the port with ra = 7, any_busy = 1;
  - then we = wclr = 1, wa = 7, wd = 0x55 → same-cycle rbusy = 0 (bypass), next cycle busy clear and any_busy = 0.
- Simultaneous: reg 9 busy; rsv_a = 9 and wclr with wa = 9 in the same cycle → busy[9] remains 1 and regs[9] = wd.
- Multi-port: NUM_RD = 3, ra = {3,3,4} after writes 3 = 0x11 and 4 = 0x22 → rd = {0x11,0x11,0x22}; rsv_a = 4 → next cycle rbusy = 3'b100.

Source files
------------

// File: rtl/mips_rf_pkg.sv
// Shared defaults and types for the MIPS register file with scoreboard.
package mips_rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: storage lookup, zero-register mask,
// write-to-read bypass and busy-bit lookup.
module rf_read_port
  import mips_rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic [DATA_W-1:0]      regs [2**ADDR_W],
  input  logic [(2**ADDR_W)-1:0] busy,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      wa,
  input  logic [DATA_W-1:0]      wd,
  input  logic [ADDR_W-1:0]      ra,
  output logic [DATA_W-1:0]      rd,
  output logic                   rbusy
);

  localparam bit BYP_EN = (BYPASS != 0);

  logic ra_zero;
  logic bypass_hit;

  assign ra_zero    = (ra == ADDR_W'(ZERO_REG));
  assign bypass_hit = BYP_EN && we && (wa != ADDR_W'(ZERO_REG)) && (ra == wa);

  always_comb begin
    rd    = regs[ra];
    rbusy = busy[ra];
    if (ra_zero) begin
      rd    = '0;
      rbusy = 1'b0;
    end else if (bypass_hit) begin
      // Writeback data is already valid this cycle, so the hazard is resolved.
      rd    = wd;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/mips_regfile_sb.sv
// Parametrised MIPS register file with hardwired zero register, optional
// write-to-read bypass and a per-register busy scoreboard for RAW detection.
module mips_regfile_sb
  import mips_rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     wclr,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     rsv,
  input  logic [ADDR_W-1:0]        rsv_a,
  output logic                     any_busy
);

  localparam int NUM_REGS = 2**ADDR_W;

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("mips_regfile_sb: NUM_RD must be in 1..4");
  end

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                wa_nz;
  logic                we_eff;

  assign wa_nz = (wa != ADDR_W'(ZERO_REG));
  // Gating with rst keeps the bypass from leaking wd onto rd while in reset.
  assign we_eff = we & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && wa_nz) begin
      regs[wa] <= wd;
    end
  end

  // Clear first, then set: a new reservation supersedes the retiring producer.
  always_comb begin
    busy_nxt = busy;
    if (wclr && wa_nz) busy_nxt[wa] = 1'b0;
    if (rsv && (rsv_a != ADDR_W'(ZERO_REG))) busy_nxt[rsv_a] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  assign any_busy = |busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_port (
      .regs  (regs),
      .busy  (busy),
      .we    (we_eff),
      .wa    (wa),
      .wd    (wd),
      .ra    (ra[k*ADDR_W +: ADDR_W]),
      .rd    (rd[k*DATA_W +: DATA_W]),
      .rbusy (rbusy[k])
    );
  end

endmodule
